// File: rtl/ascii_tx_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the ASCII frame transmitter.
package ascii_tx_pkg;

  // Frame geometry and fixed bytes
  localparam int         FRAME_LEN  = 8;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Largest value representable in three decimal digits
  localparam int         DEC_MAX    = 999;

  // Transmit FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_CONV    = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
      end
    end
    return {adj[10:0], bit_in};
  endfunction

  // ASCII character for a single BCD digit
  function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/ascii_frame_tx_bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// The start cycle loads the operand and performs the first shift; the remaining nine
// shifts follow on consecutive cycles, so o_done pulses ten cycles after i_start is
// raised and o_bcd holds the result until the next start.
module bin2bcd_seq
  import ascii_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [9:0]  i_bin,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  logic [9:0]  r_shift;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic        r_done;

  // Shift engine: load on start, then one double-dabble step per cycle until ten bits are consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 10'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 4'd0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bcd   <= dd_step(12'd0, i_bin[9]);
        r_shift <= {i_bin[8:0], 1'b0};
        r_cnt   <= 4'd1;
        r_run   <= 1'b1;
      end else if (r_run) begin
        r_bcd   <= dd_step(r_bcd, r_shift[9]);
        r_shift <= {r_shift[8:0], 1'b0};
        r_cnt   <= r_cnt + 4'd1;
        if (r_cnt == 4'd9) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/ascii_frame_tx.sv
// ASCII frame transmitter: saturates a binary value to 0..999, converts it to BCD and
// hands an 8-byte frame (header, 3 digits, 2 unit bytes, CR, LF) to a UART byte sender.
//
// Handshake with the byte sender: tx_ready high means the sender can take a byte. The
// block answers with a single-cycle po_sig carrying po_data, then waits for tx_ready to
// go low (byte taken) before it may offer the next byte on a later tx_ready high. A byte
// is therefore never offered twice, and a stuck-low tx_ready simply stalls the frame.
module ascii_frame_tx
  import ascii_tx_pkg::*;
#(
  parameter logic [7:0] HEADER = 8'h7E,
  parameter logic [7:0] UNIT0  = 8'h6D,
  parameter logic [7:0] UNIT1  = 8'h6D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] data_in,
  input  logic        data_sig,
  input  logic        tx_ready,
  output logic [7:0]  po_data,
  output logic        po_sig,
  output logic        busy,
  output logic        sat,
  output logic        drop,
  output logic [2:0]  o_dbg_state
);

  logic [2:0]  r_state;
  logic [19:0] r_value;
  logic [2:0]  r_idx;
  logic [7:0]  r_po_data;
  logic        r_po_sig;
  logic        r_busy;
  logic        r_sat;
  logic        r_drop;

  logic        w_over;
  logic [9:0]  w_conv_bin;
  logic        w_conv_start;
  logic        w_conv_done;
  logic [11:0] w_bcd;
  logic [7:0]  w_byte;
  logic        w_last_byte;

  // Saturation of the captured value and converter kick-off during LOAD
  assign w_over       = (r_value > 20'(DEC_MAX));
  assign w_conv_bin   = w_over ? 10'(DEC_MAX) : r_value[9:0];
  assign w_conv_start = (r_state == ST_LOAD);
  assign w_last_byte  = (r_idx == 3'(FRAME_LEN - 1));

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_conv_start),
    .i_bin   (w_conv_bin),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  // Byte mux: select the frame byte addressed by the current index
  always_comb begin
    w_byte = HEADER;
    case (r_idx)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = digit_ascii(w_bcd[11:8]);
      3'd2:    w_byte = digit_ascii(w_bcd[7:4]);
      3'd3:    w_byte = digit_ascii(w_bcd[3:0]);
      3'd4:    w_byte = UNIT0;
      3'd5:    w_byte = UNIT1;
      3'd6:    w_byte = ASCII_CR;
      3'd7:    w_byte = ASCII_LF;
      default: w_byte = HEADER;
    endcase
  end

  // Frame FSM: capture, saturate, convert, then step through the bytes with the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_value <= 20'd0;
      r_idx   <= 3'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_sig) begin
            r_value <= data_in;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_idx   <= 3'd0;
          r_state <= ST_CONV;
        end
        ST_CONV: begin
          if (w_conv_done) begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_ready) begin
            if (w_last_byte) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_SEND;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs: byte strobe, saturation pulse and drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_po_data <= 8'h00;
      r_po_sig  <= 1'b0;
      r_sat     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_po_sig <= 1'b0;
      r_sat    <= (r_state == ST_LOAD) && w_over;
      // Any strobe outside IDLE (including the cycle that returns to IDLE) is discarded
      r_drop   <= data_sig && (r_state != ST_IDLE);
      if ((r_state == ST_SEND) && tx_ready) begin
        r_po_data <= w_byte;
        r_po_sig  <= 1'b1;
      end
    end
  end

  assign po_data     = r_po_data;
  assign po_sig      = r_po_sig;
  assign busy        = r_busy;
  assign sat         = r_sat;
  assign drop        = r_drop;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ascii_frame_tx.sv
// Self-checking bench for ascii_frame_tx with a behavioural UART-ready model and a
// frame reference model computed from decimal arithmetic.
module tb_ascii_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] data_in = 20'd0;
  logic        data_sig = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  po_data;
  logic        po_sig;
  logic        busy;
  logic        sat;
  logic        drop;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pulse_cyc[$];
  int         cyc_now = 0;
  int         sat_cnt = 0;
  int         drop_cnt = 0;
  int         low_left = 0;
  int         dly_lo = 1;
  int         dly_hi = 4;
  int         stall_pulse = -1;
  int         stall_len = 50;

  // clock / reset block
  always #5 clk = ~clk;

  ascii_frame_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_sig    (data_sig),
    .tx_ready    (tx_ready),
    .po_data     (po_data),
    .po_sig      (po_sig),
    .busy        (busy),
    .sat         (sat),
    .drop        (drop),
    .o_dbg_state (dbg_state)
  );

  // Byte monitor and uart_tx readiness model: ready drops right after a strobe and
  // comes back after a random (or forced stall) number of cycles.
  always @(negedge clk) begin
    cyc_now++;
    if (!rst_n) begin
      tx_ready = 1'b1;
      low_left = 0;
    end else begin
      if (sat === 1'b1) sat_cnt++;
      if (drop === 1'b1) drop_cnt++;
      if (po_sig === 1'b1) begin
        got_q.push_back(po_data);
        pulse_cyc.push_back(cyc_now);
        tx_ready = 1'b0;
        if (got_q.size() == stall_pulse) low_left = stall_len;
        else low_left = int'($urandom_range(dly_lo, dly_hi));
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) tx_ready = 1'b1;
      end
    end
  end

  // Drive one frame and check it against the decimal reference model.
  task automatic do_frame(input logic [19:0] val, input int lo, input int hi,
                          input bit chk_lat, input int drop_at, input bit drop_last);
    int base, sat0, drop0, cyc, npo, v, exp_drop;
    logic exp_sat;
    logic [7:0] fr [8];
    logic [7:0] got, exp;
    bit pend;
    dly_lo = lo;
    dly_hi = hi;
    cyc = 0;
    while ((busy !== 1'b0 || tx_ready !== 1'b1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= 500) begin bad++; $display("FAIL idle_wait val=%0d busy=%b want=0", val, busy); end

    v = (val > 20'd999) ? 999 : int'(val);
    exp_sat = (val > 20'd999);
    fr[0] = 8'h7E;
    fr[1] = 8'(48 + v / 100);
    fr[2] = 8'(48 + (v / 10) % 10);
    fr[3] = 8'(48 + v % 10);
    fr[4] = 8'h6D;
    fr[5] = 8'h6D;
    fr[6] = 8'h0D;
    fr[7] = 8'h0A;
    for (int i = 0; i < 8; i++) exp_q.push_back(fr[i]);
    exp_drop = (drop_at > 0 || drop_last) ? 1 : 0;

    base = got_q.size();
    sat0 = sat_cnt;
    drop0 = drop_cnt;
    data_in = val;
    data_sig = 1'b1;
    @(negedge clk);
    data_sig = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise val=%0d got=%b want=1", val, busy); end

    cyc = 0;
    npo = 0;
    pend = 1'b0;
    while (cyc < 3000 && !(got_q.size() >= base + 8 && busy === 1'b0)) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        data_sig = 1'b0;
        pend = 1'b0;
        total++;
        if (drop !== 1'b1) begin bad++; $display("FAIL drop_pulse val=%0d got=%b want=1", val, drop); end
        if (drop_last) begin
          total++;
          if (busy !== 1'b0) begin bad++; $display("FAIL busy_fall val=%0d got=%b want=0", val, busy); end
        end
      end
      if (cyc == 1) begin
        total++;
        if (sat !== exp_sat) begin bad++; $display("FAIL sat_timing val=%0d got=%b want=%b", val, sat, exp_sat); end
      end
      if (po_sig === 1'b1) begin
        npo++;
        if (npo == 1 && chk_lat) begin
          total++;
          if (cyc != 12) begin bad++; $display("FAIL first_po_latency val=%0d got=%0d want=12", val, cyc); end
        end
      end
      if (drop_at > 0 && cyc == drop_at) begin
        data_in = 20'd456;
        data_sig = 1'b1;
        pend = 1'b1;
      end
      if (drop_last && po_sig === 1'b1 && npo == 8) begin
        data_in = 20'd321;
        data_sig = 1'b1;
        pend = 1'b1;
      end
    end
    data_sig = 1'b0;
    #1;
    total++;
    if (cyc >= 3000) begin bad++; $display("FAIL frame_timeout val=%0d got=%0d want<3000", val, cyc); end
    total++;
    if (got_q.size() != base + 8) begin
      bad++; $display("FAIL byte_count val=%0d got=%0d want=8", val, got_q.size() - base);
    end
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      got = (got_q.size() > base + i) ? got_q[base + i] : 8'hxx;
      total++;
      if (got !== exp) begin bad++; $display("FAIL byte%0d val=%0d got=%h want=%h", i, val, got, exp); end
    end
    total++;
    if (sat_cnt - sat0 != int'(exp_sat)) begin
      bad++; $display("FAIL sat_count val=%0d got=%0d want=%0d", val, sat_cnt - sat0, exp_sat);
    end
    total++;
    if (drop_cnt - drop0 != exp_drop) begin
      bad++; $display("FAIL drop_count val=%0d got=%0d want=%0d", val, drop_cnt - drop0, exp_drop);
    end
    if (drop_last) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL late_sig_ignored got=%b want=0", busy); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (po_data !== 8'h00) begin bad++; $display("FAIL rst_po_data got=%h want=00", po_data); end
    total++; if (po_sig !== 1'b0) begin bad++; $display("FAIL rst_po_sig got=%b want=0", po_sig); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (sat !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b want=0", sat); end
    total++; if (drop !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b want=0", drop); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_frame(20'd123, 20, 20, 1'b1, 0, 1'b0);
  endtask

  task automatic test_values();
    do_frame(20'd0, 1, 3, 1'b1, 0, 1'b0);
    do_frame(20'd999, 1, 3, 1'b1, 0, 1'b0);
    do_frame(20'd1000, 1, 3, 1'b1, 0, 1'b0);
    do_frame(20'hFFFFF, 1, 3, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall();
    int b, gap;
    b = got_q.size();
    stall_pulse = b + 4;
    do_frame(20'd246, 2, 3, 1'b0, 0, 1'b0);
    stall_pulse = -1;
    gap = (pulse_cyc.size() >= b + 5) ? pulse_cyc[b + 4] - pulse_cyc[b + 3] : 0;
    total++;
    if (gap <= 50) begin bad++; $display("FAIL stall_gap got=%0d want>50", gap); end
  endtask

  task automatic test_drop();
    do_frame(20'd123, 2, 4, 1'b0, 30, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_frame(20'd77, 1, 2, 1'b0, 0, 1'b1);
    do_frame(20'd888, 1, 1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc, npo;
    cyc = 0;
    while ((busy !== 1'b0 || tx_ready !== 1'b1) && cyc < 500) begin @(negedge clk); cyc++; end
    dly_lo = 2;
    dly_hi = 5;
    data_in = 20'd555;
    data_sig = 1'b1;
    @(negedge clk);
    data_sig = 1'b0;
    cyc = 0;
    npo = 0;
    while (npo < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (po_sig === 1'b1) npo++;
    end
    total++;
    if (npo < 3) begin bad++; $display("FAIL reset_mid_reach got=%0d want=3", npo); end
    rst_n = 1'b0;
    #1;
    total++; if (po_sig !== 1'b0) begin bad++; $display("FAIL po_sig_async got=%b want=0", po_sig); end
    @(negedge clk);
    total++; if (po_data !== 8'h00) begin bad++; $display("FAIL mid_po_data got=%h want=00", po_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL mid_state got=%0d want=0", dbg_state); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(20'd789, 2, 5, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [19:0] r;
    for (int k = 0; k < 8; k++) begin
      if (k % 3 == 2) r = 20'($urandom());
      else r = 20'($urandom_range(0, 1200));
      do_frame(r, 1, 6, 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_stall();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_frame_tx.md
# ascii_frame_tx

Transmit-side counterpart of the UART ASCII frame parser. Accepts a binary measurement value, saturates it to three decimal digits and converts it to BCD with a fixed-latency sequential converter. It then emits an 8-byte ASCII frame, one byte at a time, to the UART byte transmitter using a ready/strobe handshake. The block sits between the measurement/display logic and `uart_tx`, and produces exactly the frame format the receive-side parser decodes.

## Interface
- `HEADER`, 8'h7E: frame start byte (byte 0).
- `UNIT0`, 8'h6D: byte 4 (ASCII 'm').
- `UNIT1`, 8'h6D: byte 5 (ASCII 'm').
- `clk`  in  1  system clock; the block uses one clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data_in`  in  20  unsigned binary value to send.
- `data_sig`  in  1  one-cycle strobe; `data_in` is valid in the same cycle.
- `tx_ready`  in  1  high when `uart_tx` is idle and able to accept a byte.
- `po_data`  out  8  byte to `uart_tx`.
- `po_sig`  out  1  one-cycle strobe; `po_data` is valid in the same cycle.
- `busy`  out  1  high from acceptance of a frame until its last byte has been handed off.
- `sat`  out  1  one-cycle pulse when the accepted value exceeded 999.
- `drop`  out  1  one-cycle pulse when `data_sig` arrives while `busy` is high.

## Operation
- Frame, in order: `HEADER`, hundreds digit, tens digit, ones digit, `UNIT0`, `UNIT1`, 8'h0D, 8'h0A. Each digit byte is 8'h30 plus the BCD digit.
- States: IDLE → LOAD → CONV → SEND → WAIT_LO → back to SEND, or to IDLE after byte 7.
- IDLE: `data_sig`=1 captures `data_in` and moves to LOAD.
- LOAD (1 cycle): if the captured value is greater than 999, use 10'd999 and pulse `sat`. Otherwise use the captured value[9:0]. Initialise the converter and clear the byte index to 0.
- CONV (exactly 10 cycles): 10-bit double-dabble, one shift per cycle, producing a 12-bit BCD result.
- SEND: when `tx_ready`=1, drive `po_data` with byte[index], pulse `po_sig` for one cycle, and move to WAIT_LO.
- WAIT_LO: wait for `tx_ready`=0, then:
  - if index = 7, go to IDLE;
  - otherwise increment index and go to SEND.
- No byte is ever issued twice. Handing off a byte requires `tx_ready` to fall and then rise again.
- `data_sig` in any state other than IDLE: ignore it, leave the captured value unchanged, and pulse `drop` in the next cycle.
- `data_sig` in the same cycle the FSM returns to IDLE counts as busy and is dropped. It is accepted from the following cycle onward.
- Byte index is 3 bits and runs 0..7; it never wraps mid-frame.

## Timing
- Reset values: `po_data`=8'h00, `po_sig`=0, `busy`=0, `sat`=0, `drop`=0, state=IDLE, index=0, captured value=0.
- All outputs are registered.
- If `data_sig` is sampled at edge N:
  - `busy`=1 after edge N;
  - `sat` is high for one cycle after edge N+1;
  - BCD is ready after edge N+11;
  - the first `po_sig` is asserted after edge N+12 at the earliest, if `tx_ready`=1.
- Minimum byte spacing is 2 cycles: SEND, then WAIT_LO with `tx_ready` already low. Actual spacing is set by `uart_tx`.
- `busy` falls in the cycle the FSM enters IDLE, one edge after `tx_ready`=0 is seen for byte 7.
- `rst_n` low mid-frame: immediate return to reset values, and `po_sig` deasserts asynchronously. The next frame starts at `HEADER`; no partial frame is resumed.
- `tx_ready` held low indefinitely: the block waits with no timeout.

## Structure
- Shared package/include `ascii_tx_pkg` holds:
  - the state encoding;
  - `FRAME_LEN`=8;
  - `ASCII_ZERO`=8'h30, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A;
  - `DEC_MAX`=999.
- Header and unit bytes stay as parameters.
- Sub-module `bin2bcd_seq`: 10-bit sequential double-dabble with `start` input, `done` pulse and 12-bit BCD output, fixed latency of 10 cycles.
- FSM, byte mux and handshake logic live in the top module.

## Test plan
- `data_in`=123, `tx_ready` model drops 1 cycle after `po_sig` and rises 20 cycles later -> bytes 7E 31 32 33 6D 6D 0D 0A; `sat`=0; `busy` low after the last byte.
- `data_in`=0 -> digit bytes 30 30 30. `data_in`=999 -> 39 39 39 with `sat`=0.
- `data_in`=1000, then `data_in`=20'hFFFFF -> both frames carry 39 39 39, with one `sat` pulse each.
- `tx_ready` held low for 50 cycles after byte 3 -> no `po_sig` during the stall; resumes with 6D; exactly 8 `po_sig` pulses in total.
- `data_sig` with 456 during frame 123 -> one `drop` pulse; frame is still 31 32 33; a `data_sig` issued after `busy` falls is accepted.
- `rst_n` asserted after byte 2 -> all outputs return to 0; next `data_sig`=789 -> full frame starting with 7E, digits 37 38 39.
